// File: rtl/pe_seq_pkg.sv
// Shared types and defaults for the PE array pass sequencer and the PE array it drives.
package pe_seq_pkg;

  localparam int unsigned DefDelayCycles = 10;
  localparam int unsigned DefRowBusWidth = 2;
  localparam int unsigned DefColBusWidth = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StKey,
    StStream,
    StDrain,
    StDone,
    StAbort
  } seq_state_e;

  typedef struct packed {
    logic                      kl_type;
    logic [DefRowBusWidth-1:0] row;
    logic [DefColBusWidth-1:0] col;
  } kl_bus_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_seq_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module pe_seq_cnt
  import pe_seq_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] cnt,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one PE array pass: flush, key broadcast, operand stream, pipeline drain, done.
// Optional PE_SEQ_PERF_EN adds perf_stream_cnt, a saturating count of data_en cycles.
module pe_array_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned ROW_BUS_WIDTH = DefRowBusWidth,
  parameter int unsigned COL_BUS_WIDTH = DefColBusWidth,
  parameter int unsigned DELAY_CYCLES  = DefDelayCycles,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ROW_BUS_WIDTH-1:0] cmd_row,
  input  logic [COL_BUS_WIDTH-1:0] cmd_col,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     abort,
  output logic                     pe_flush,
  output logic                     pe_rst,
  output logic                     kl_valid,
  output logic                     kl_type,
  output logic [ROW_BUS_WIDTH-1:0] kl_row,
  output logic [COL_BUS_WIDTH-1:0] kl_col,
  output logic                     data_en,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_stream_cnt
`endif
);

  localparam int unsigned CntW = max_u(LEN_WIDTH, $clog2(DELAY_CYCLES + 1));

  seq_state_e state_q, state_d;
  logic [ROW_BUS_WIDTH-1:0] row_q, row_d;
  logic [COL_BUS_WIDTH-1:0] col_q, col_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic                     rst_hold_q;

  logic            capture;
  logic            cnt_load;
  logic            cnt_dec;
  logic [CntW-1:0] cnt_val;
  logic [CntW-1:0] cnt_unused;
  logic            cnt_zero;
  logic            abortable;

  pe_seq_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt_unused),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          capture = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: state_d = StKey;
      StKey: begin
        cnt_load = 1'b1;
        if (len_q != '0) begin
          cnt_val = CntW'(len_q) - CntW'(1);
          state_d = StStream;
        end else begin
          cnt_val = CntW'(DELAY_CYCLES);
          state_d = StDrain;
        end
      end
      StStream: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CntW'(DELAY_CYCLES);
          state_d  = StDrain;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDrain: begin
        if (cnt_zero) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides whatever the active phase would have done next.
    if (abortable && abort) begin
      state_d = StAbort;
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    len_d = len_q;
    if (capture) begin
      row_d = cmd_row;
      col_d = cmd_col;
      len_d = cmd_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      len_q      <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      len_q      <= len_d;
      rst_hold_q <= 1'b0;
    end
  end

  always_comb begin
    abortable = (state_q == StFlush) || (state_q == StKey) ||
                (state_q == StStream) || (state_q == StDrain);
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    pe_flush  = (state_q == StFlush) || (state_q == StAbort);
    // PE reset stays asserted until the first clock edge after rst_n releases.
    pe_rst    = rst_hold_q || pe_flush;
    kl_valid  = (state_q == StKey);
    kl_type   = (state_q == StKey);
    kl_row    = row_q;
    kl_col    = col_q;
    data_en   = (state_q == StStream);
    done      = (state_q == StDone);
    aborted   = (state_q == StAbort);
  end

`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (data_en && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stream_cnt = perf_q;
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: pass-age reference model plus directed literal pins.
module tb_pe_array_sequencer;

  localparam int unsigned RW  = 2;
  localparam int unsigned CW  = 2;
  localparam int unsigned DLY = 10;
  localparam int unsigned LW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic [LW-1:0] cmd_len;
  logic          abort;
  logic          pe_flush;
  logic          pe_rst;
  logic          kl_valid;
  logic          kl_type;
  logic [RW-1:0] kl_row;
  logic [CW-1:0] kl_col;
  logic          data_en;
  logic          busy;
  logic          done;
  logic          aborted;
`ifdef PE_SEQ_PERF_EN
  logic [31:0]   perf_stream_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pe_array_sequencer #(
    .ROW_BUS_WIDTH (RW),
    .COL_BUS_WIDTH (CW),
    .DELAY_CYCLES  (DLY),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .pe_flush  (pe_flush),
    .pe_rst    (pe_rst),
    .kl_valid  (kl_valid),
    .kl_type   (kl_type),
    .kl_row    (kl_row),
    .kl_col    (kl_col),
    .data_en   (data_en),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
`ifdef PE_SEQ_PERF_EN
    ,
    .perf_stream_cnt (perf_stream_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is tracked by its age in cycles since acceptance (0 = idle).
  int            m_age;
  bit            m_abort;
  bit            m_hold;
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic [LW-1:0] m_len;
  logic [31:0]   m_perf;

  function automatic bit m_stream();
    return (m_age >= 3) && (m_age <= 2 + int'(m_len));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age   <= 0;
      m_abort <= 1'b0;
      m_hold  <= 1'b1;
      m_row   <= '0;
      m_col   <= '0;
      m_len   <= '0;
      m_perf  <= '0;
    end else begin
      m_hold <= 1'b0;
      if (m_stream() && (m_perf != 32'hFFFF_FFFF)) m_perf <= m_perf + 32'd1;
      if (m_abort) begin
        m_abort <= 1'b0;
      end else if (m_age == 0) begin
        if (cmd_valid) begin
          m_age <= 1;
          m_row <= cmd_row;
          m_col <= cmd_col;
          m_len <= cmd_len;
        end
      end else if (m_age == 4 + int'(m_len) + int'(DLY)) begin
        m_age <= 0;
      end else if (abort) begin
        m_abort <= 1'b1;
        m_age   <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit e_idle;
    bit e_flush;
    if (chk_en) begin
      e_idle  = (m_age == 0) && !m_abort;
      e_flush = (m_age == 1) || m_abort;
      chk("cmd_ready", 32'(cmd_ready), 32'(e_idle));
      chk("busy", 32'(busy), 32'(!e_idle));
      chk("pe_flush", 32'(pe_flush), 32'(e_flush));
      chk("pe_rst", 32'(pe_rst), 32'(e_flush || m_hold));
      chk("kl_valid", 32'(kl_valid), 32'(m_age == 2));
      chk("kl_type", 32'(kl_type), 32'(m_age == 2));
      chk("kl_row", 32'(kl_row), 32'(m_row));
      chk("kl_col", 32'(kl_col), 32'(m_col));
      chk("data_en", 32'(data_en), 32'(m_stream()));
      chk("done", 32'(done), 32'(m_age == 4 + int'(m_len) + int'(DLY)));
      chk("aborted", 32'(aborted), 32'(m_abort));
`ifdef PE_SEQ_PERF_EN
      chk("perf_stream_cnt", perf_stream_cnt, m_perf);
`endif
    end
  end

  // Per-pass observations, cycle numbers relative to the acceptance cycle 0.
  int            r_flush1, r_flush2, r_kl, r_de_first, r_de_last, r_de_cnt;
  int            r_done, r_ab, r_ready;
  bit            r_ab_flush;
  logic [RW-1:0] r_kr;
  logic [CW-1:0] r_kc;

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic run_pass(input logic [RW-1:0] row, input logic [CW-1:0] col,
                          input logic [LW-1:0] len, input int abort_cyc, input bit hold,
                          input int ncyc);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    wait_idle();
    r_flush1 = -1; r_flush2 = -1; r_kl = -1; r_de_first = -1; r_de_last = -1;
    r_de_cnt = 0; r_done = -1; r_ab = -1; r_ready = -1; r_ab_flush = 1'b0;
    r_kr = '0; r_kc = '0;
    cmd_valid = 1'b1;
    cmd_row   = row;
    cmd_col   = col;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = hold;
    for (int c = 1; c <= ncyc; c++) begin
      abort = (c == abort_cyc);
      @(negedge clk);
      if (pe_flush) begin
        if (r_flush1 < 0) r_flush1 = c;
        else if (r_flush2 < 0) r_flush2 = c;
      end
      if (kl_valid && kl_type && (r_kl < 0)) begin
        r_kl = c;
        r_kr = kl_row;
        r_kc = kl_col;
      end
      if (data_en) begin
        r_de_cnt++;
        if (r_de_first < 0) r_de_first = c;
        r_de_last = c;
      end
      if (done && (r_done < 0)) r_done = c;
      if (aborted && (r_ab < 0)) begin
        r_ab       = c;
        r_ab_flush = pe_flush;
      end
      if (cmd_ready && (r_ready < 0)) r_ready = c;
      @(posedge clk); #1;
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_row   = '0;
    cmd_col   = '0;
    cmd_len   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pe_rst", 32'(pe_rst), 32'd1);
    chk("rst_pe_flush", 32'(pe_flush), 32'd0);
    chk("rst_kl_row", 32'(kl_row), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("pe_rst_release", 32'(pe_rst), 32'd0);

    // Normal pass row=2 col=1 len=4.
    run_pass(2'd2, 2'd1, 16'd4, -1, 1'b0, 22);
    chk("n_flush_cyc", 32'(r_flush1), 32'd1);
    chk("n_kl_cyc", 32'(r_kl), 32'd2);
    chk("n_kl_row", 32'(r_kr), 32'd2);
    chk("n_kl_col", 32'(r_kc), 32'd1);
    chk("n_de_first", 32'(r_de_first), 32'd3);
    chk("n_de_last", 32'(r_de_last), 32'd6);
    chk("n_de_cnt", 32'(r_de_cnt), 32'd4);
    chk("n_done_cyc", 32'(r_done), 32'd18);
    chk("n_ready_cyc", 32'(r_ready), 32'd19);

    run_pass(2'd3, 2'd2, 16'd7, -1, 1'b0, 24);
    chk("l7_de_cnt", 32'(r_de_cnt), 32'd7);
    chk("l7_done_cyc", 32'(r_done), 32'd21);
`ifdef PE_SEQ_PERF_EN
    @(negedge clk);
    chk("perf_two_pass", perf_stream_cnt, 32'd11);
`endif

    // Zero-length pass.
    run_pass(2'd1, 2'd3, 16'd0, -1, 1'b0, 18);
    chk("z_de_cnt", 32'(r_de_cnt), 32'd0);
    chk("z_done_cyc", 32'(r_done), 32'd14);

    // Abort on the second data_en cycle.
    run_pass(2'd0, 2'd2, 16'd6, 4, 1'b0, 30);
    chk("a_de_cnt", 32'(r_de_cnt), 32'd2);
    chk("a_aborted_cyc", 32'(r_ab), 32'd5);
    chk("a_flush_at_abort", 32'(r_ab_flush), 32'd1);
    chk("a_ready_cyc", 32'(r_ready), 32'd6);
    chk("a_no_done", 32'(r_done), 32'hFFFF_FFFF);

    // Back-to-back with cmd_valid held high.
    run_pass(2'd2, 2'd2, 16'd4, -1, 1'b1, 24);
    chk("b_done_cyc", 32'(r_done), 32'd18);
    chk("b_ready_cyc", 32'(r_ready), 32'd19);
    chk("b_second_flush", 32'(r_flush2), 32'd20);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 15) == 0);
      cmd_row   = RW'($urandom);
      cmd_col   = CW'($urandom);
      cmd_len   = ($urandom_range(0, 7) == 0) ? 16'd0 : LW'($urandom_range(1, 12));
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;

    // Reset asserted mid-stream.
    wait_idle();
    cmd_valid = 1'b1;
    cmd_len   = 16'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("mr_streaming", 32'(data_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_pe_rst", 32'(pe_rst), 32'd1);
    chk("mr_data_en", 32'(data_en), 32'd0);
    chk("mr_pe_flush", 32'(pe_flush), 32'd0);
    chk("mr_kl_row", 32'(kl_row), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_aborted", 32'(aborted), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Maximum length streams exactly 2^16-1 cycles.
    run_pass(2'd1, 2'd1, 16'hFFFF, -1, 1'b0, 65552);
    chk("max_de_cnt", 32'(r_de_cnt), 32'd65535);
    chk("max_done_cyc", 32'(r_done), 32'd65549);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
